// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and controller state definitions for the alu and its arbiter.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_EQ   = 4'd11;
    localparam logic [3:0] OP_GT   = 4'd12;
    localparam logic [3:0] OP_LSH  = 4'd13;
    localparam logic [3:0] OP_RSH  = 4'd14;

    localparam int FLG_ZERO   = 4;
    localparam int FLG_SIGN   = 3;
    localparam int FLG_CARRY  = 2;
    localparam int FLG_OVF    = 1;
    localparam int FLG_PARITY = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // mul and div are the multi-cycle paths through the alu
    function automatic logic is_slow_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational alu; every output is forced to zero while en is low.
module alu
    import alu_pkg::*;
(
    input  logic        en,
    input  logic [3:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        bin,
    output logic [31:0] result,
    output logic [31:0] sum,
    output logic [31:0] diff,
    output logic        cout,
    output logic        bout,
    output logic [4:0]  flags
);

    logic [32:0] sum_w;
    logic [32:0] diff_w;
    logic [31:0] res;
    logic        carry;
    logic        ovf;
    logic [4:0]  flags_w;

    always_comb begin
        sum_w   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        diff_w  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                res   = sum_w[31:0];
                carry = sum_w[32];
                ovf   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            OP_SUB: begin
                res   = diff_w[31:0];
                carry = diff_w[32];
                ovf   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            OP_NOT:  res = ~a;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_NAND: res = ~(a & b);
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_MUL:  res = a * b;
            OP_DIV:  res = (b == '0) ? '0 : a / b;
            OP_EQ:   res = {31'd0, a == b};
            OP_GT:   res = {31'd0, a > b};
            OP_LSH:  res = a << b[4:0];
            OP_RSH:  res = a >> b[4:0];
            default: res = '0;
        endcase

        flags_w             = '0;
        flags_w[FLG_ZERO]   = (res == '0);
        flags_w[FLG_SIGN]   = res[31];
        flags_w[FLG_CARRY]  = carry;
        flags_w[FLG_OVF]    = ovf;
        flags_w[FLG_PARITY] = ^res;

        result = en ? res : '0;
        flags  = en ? flags_w : '0;
        sum    = en ? sum_w[31:0] : '0;
        diff   = en ? diff_w[31:0] : '0;
        cout   = en & sum_w[32];
        bout   = en & diff_w[32];
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Round-robin arbiter sharing one alu between two command ports, with opcode-dependent
// execute latency and a held valid/ready response port.
module alu_arbiter_ctrl
    import alu_pkg::*;
#(
    parameter int SLOW_LAT = 4,
    parameter int FAST_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        busy
);

    localparam int MAX_LAT = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    if (SLOW_LAT < 1 || FAST_LAT < 1) begin : g_bad_lat
        $error("alu_arbiter_ctrl: SLOW_LAT and FAST_LAT must both be >= 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             cin_q, cin_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [4:0]       rsp_flags_q, rsp_flags_d;

    logic             in_idle;
    logic             grant_id;
    logic             accept;
    logic [3:0]       sel_op;
    logic             alu_en;
    logic [31:0]      alu_result;
    logic [4:0]       alu_flags;

    function automatic logic [CNT_W-1:0] lat_cnt(input logic [3:0] op);
        return is_slow_op(op) ? CNT_W'(SLOW_LAT - 1) : CNT_W'(FAST_LAT - 1);
    endfunction

    // Handshakes: a command moves on the rising edge where reqN_valid & reqN_ready, and ready is
    // raised only in IDLE for the granted requester; a response is held from capture until the
    // edge where rsp_valid & rsp_ready.
    always_comb begin
        in_idle    = (state_q == ST_IDLE);
        grant_id   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = in_idle & req0_valid & ~grant_id;
        req1_ready = in_idle & req1_valid & grant_id;
        accept     = req0_ready | req1_ready;
        sel_op     = grant_id ? req1_opcode : req0_opcode;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d         = sel_op;
                    a_d          = grant_id ? req1_a : req0_a;
                    b_d          = grant_id ? req1_b : req0_b;
                    cin_d        = grant_id ? req1_cin : req0_cin;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = lat_cnt(sel_op);
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_en = (state_q == ST_EXEC);

    alu u_alu (
        .en     (alu_en),
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .cin    (cin_q),
        .bin    (cin_q),
        .result (alu_result),
        .sum    (),
        .diff   (),
        .cout   (),
        .bout   (),
        .flags  (alu_flags)
    );

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl: a transaction-level model with a per-cycle compare process,
// plus literal expectations for the listed scenarios.
module tb_alu_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_opcode = '0, req1_opcode = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_cin = 1'b0, req1_cin = 1'b0;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_cyc = -1;

    int          acc_log[$];
    int          acc_cyc[$];
    logic [37:0] rsp_log[$];
    logic [37:0] exp_q[$];

    bit m_busy = 1'b0;
    bit m_resp = 1'b0;
    bit m_last = 1'b1;
    int m_left = 0;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.SLOW_LAT(4), .FAST_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_opcode(req0_opcode),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_opcode(req1_opcode),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference alu: returns {result, zero, sign, carry, overflow, parity}
    function automatic logic [36:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        longint unsigned wa, wb, wc, t;
        logic [31:0] r;
        logic c, v;
        wa = a; wb = b; wc = cin;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                t = wa + wb + wc;
                r = t[31:0];
                c = (t > 64'hFFFF_FFFF);
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                t = wa - wb - wc;
                r = t[31:0];
                c = (wa < wb + wc);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:  r = ~a;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = ~(a | b);
            4'd6:  r = ~(a & b);
            4'd7:  r = a ^ b;
            4'd8:  r = ~(a ^ b);
            4'd9:  begin t = wa * wb; r = t[31:0]; end
            4'd10: r = (b == 0) ? 32'd0 : 32'(wa / wb);
            4'd11: r = (a == b) ? 32'd1 : 32'd0;
            4'd12: r = (a > b) ? 32'd1 : 32'd0;
            4'd13: r = a << b[4:0];
            4'd14: r = a >> b[4:0];
            default: r = '0;
        endcase
        return {r, (r == 0), r[31], c, v, ^r};
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        return (op == 4'd9 || op == 4'd10) ? 4 : 1;
    endfunction

    // Which requester the arbiter should be accepting right now
    function automatic bit m_rdy(input int n);
        if (!rst_n || m_busy) return 1'b0;
        if (n == 0) return req0_valid && (!req1_valid || m_last != 1'b0);
        return req1_valid && (!req0_valid || m_last != 1'b1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: one op in flight, LAT execute cycles, then a response until consumed
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
            m_left <= 0;
            m_last <= 1'b1;
            exp_q.delete();
        end else if (!m_busy) begin
            if (m_rdy(0)) begin
                m_busy <= 1'b1;
                m_last <= 1'b0;
                m_left <= lat_of(req0_opcode);
                exp_q.push_back({1'b0, ref_alu(req0_opcode, req0_a, req0_b, req0_cin)});
            end else if (m_rdy(1)) begin
                m_busy <= 1'b1;
                m_last <= 1'b1;
                m_left <= lat_of(req1_opcode);
                exp_q.push_back({1'b1, ref_alu(req1_opcode, req1_a, req1_b, req1_cin)});
            end
        end else if (!m_resp) begin
            if (m_left == 1) m_resp <= 1'b1;
            m_left <= m_left - 1;
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
            void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [37:0] e;
        if (!rst_n) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_flags", rsp_flags, 0);
        end else begin
            chk("req0_ready", req0_ready, m_rdy(0));
            chk("req1_ready", req1_ready, m_rdy(1));
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, m_resp);
            if (m_resp && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("rsp_id", rsp_id, e[37]);
                chk("rsp_result", rsp_result, e[36:5]);
                chk("rsp_flags", rsp_flags, e[4:0]);
            end
            if (req0_valid && req0_ready) begin acc_log.push_back(0); acc_cyc.push_back(cyc); end
            if (req1_valid && req1_ready) begin acc_log.push_back(1); acc_cyc.push_back(cyc); end
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back({rsp_id, rsp_result, rsp_flags});
                hs_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int n, input bit v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
        if (n == 0) begin
            req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_cin = cin;
        end
    endtask

    task automatic wait_acc(input string name, input int n, input bit drop, output int t);
        int base;
        bit got;
        base = acc_log.size();
        got = 1'b0;
        t = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #1;
            if (acc_log.size() > base) begin
                got = 1'b1;
                t = acc_cyc[base];
                chk({name, "_acc_id"}, acc_log[base], n);
            end
        end
        if (got && drop) begin
            if (n == 0) req0_valid = 1'b0;
            else req1_valid = 1'b0;
        end
        if (!got) chk({name, "_acc_timeout"}, got, 1);
    endtask

    task automatic wait_rsp(input string name, output int t);
        bit got;
        got = 1'b0;
        t = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                t = cyc;
            end
        end
        @(posedge clk);
        #1;
        if (!got) chk({name, "_rsp_timeout"}, got, 1);
    endtask

    task automatic chk_rsp(input string name, input int idx, input logic id,
                           input logic [31:0] r, input logic [4:0] f);
        logic [37:0] e;
        if (idx < 0 || idx >= rsp_log.size()) begin
            chk({name, "_missing"}, rsp_log.size(), idx + 1);
        end else begin
            e = rsp_log[idx];
            chk({name, "_id"}, e[37], id);
            chk({name, "_result"}, e[36:5], r);
            chk({name, "_flags"}, e[4:0], f);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb, tr, base, nrsp;
        bit done;

        #12;
        chk("reset_req0_ready", req0_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_result", rsp_result, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // 1: single fast add
        drive(0, 1, 4'd0, 32'd5, 32'd7, 0);
        wait_acc("t1", 0, 1, ta);
        wait_rsp("t1", tr);
        chk("t1_latency", tr - ta, 2);
        chk_rsp("t1", rsp_log.size() - 1, 0, 32'd12, 5'b00000);
        tick(1);

        // 2: tie after reset goes to req0, req1 follows one op slot later
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        drive(0, 1, 4'd1, 32'd10, 32'd10, 0);
        drive(1, 1, 4'd7, 32'hF0, 32'h0F, 0);
        wait_acc("t2a", 0, 1, ta);
        wait_acc("t2b", 1, 1, tb);
        chk("t2_spacing", tb - ta, 3);
        wait_rsp("t2", tr);
        chk_rsp("t2_req0", rsp_log.size() - 2, 0, 32'd0, 5'b10000);
        chk_rsp("t2_req1", rsp_log.size() - 1, 1, 32'hFF, 5'b00000);
        tick(1);

        // 3: slow mul
        drive(1, 1, 4'd9, 32'd3, 32'd4, 0);
        wait_acc("t3", 1, 1, ta);
        wait_rsp("t3", tr);
        chk("t3_latency", tr - ta, 5);
        chk_rsp("t3", rsp_log.size() - 1, 1, 32'd12, 5'b00000);
        tick(1);

        // 4: response back-pressure for 3 cycles with req0 pending
        rsp_ready = 1'b0;
        drive(1, 1, 4'd3, 32'hFF00FF00, 32'h0F0F0F0F, 0);
        wait_acc("t4a", 1, 1, ta);
        drive(0, 1, 4'd0, 32'h7FFFFFFF, 32'd1, 0);
        wait_rsp("t4", tr);
        tick(2);
        rsp_ready = 1'b1;
        wait_acc("t4b", 0, 1, tb);
        chk("t4_acc_after_hs", tb - hs_cyc, 1);
        chk("t4_stall_len", hs_cyc - tr, 3);
        chk_rsp("t4_and", rsp_log.size() - 1, 1, 32'h0F000F00, 5'b00000);
        wait_rsp("t4c", tr);
        chk_rsp("t4_ovf", rsp_log.size() - 1, 0, 32'h80000000, 5'b01011);
        tick(1);

        // 5: reset during slow div aborts it
        nrsp = rsp_log.size();
        drive(0, 1, 4'd10, 32'd100, 32'd7, 0);
        wait_acc("t5", 0, 1, ta);
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_rsp_valid", rsp_valid, 0);
        chk("t5_async_rsp_result", rsp_result, 0);
        chk("t5_async_rsp_flags", rsp_flags, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(0, 1, 4'd0, 32'd1, 32'd2, 0);
        drive(1, 1, 4'd0, 32'd3, 32'd4, 0);
        rst_n = 1'b1;
        wait_acc("t5a", 0, 1, ta);
        wait_acc("t5b", 1, 1, tb);
        wait_rsp("t5", tr);
        tick(1);
        chk("t5_rsp_count", rsp_log.size() - nrsp, 2);
        chk_rsp("t5_first", nrsp, 0, 32'd3, 5'b00000);
        chk_rsp("t5_second", nrsp + 1, 1, 32'd7, 5'b00001);

        // 6: opcode 15 yields zero, then alternation under continuous valid
        drive(0, 1, 4'd15, 32'hFFFFFFFF, 32'd1, 0);
        wait_acc("t6", 0, 1, ta);
        wait_rsp("t6", tr);
        chk_rsp("t6_op15", rsp_log.size() - 1, 0, 32'd0, 5'b10000);
        tick(1);
        base = acc_log.size();
        drive(0, 1, 4'd7, 32'h12345678, 32'hFFFF0000, 0);
        drive(1, 1, 4'd12, 32'd5, 32'd3, 0);
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick(1);
            if (acc_log.size() >= base + 4) done = 1'b1;
        end
        drive(0, 0, 4'd0, 32'd0, 32'd0, 0);
        drive(1, 0, 4'd0, 32'd0, 32'd0, 0);
        chk("t6_alt_done", done, 1);
        if (done) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t6_alt_id%0d", i), acc_log[base + i], (i % 2 == 0) ? 1 : 0);
                if (i > 0) chk($sformatf("t6_alt_gap%0d", i), acc_cyc[base + i] - acc_cyc[base + i - 1], 3);
            end
        end
        tick(8);
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
